// File: rtl/oj_output_checker_pkg.sv
// Shared types and helpers for the judge output checker: FSM state encoding,
// default counter width and a saturating increment.
package oj_check_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  localparam int DEF_CNT_W = 16;

  // Increment v, holding at the all-ones value of a w-bit counter (w <= 32).
  function automatic logic [31:0] sat_inc(input logic [31:0] v, input int unsigned w);
    logic [31:0] max_v;
    max_v = (w >= 32) ? 32'hFFFF_FFFF : ((32'd1 << w) - 32'd1);
    return (v >= max_v) ? v : v + 32'd1;
  endfunction

endpackage

// File: rtl/oj_output_checker_if.sv
// Sample stream and verdict bundle between the judge testbench (master) and the
// output checker (slave).
interface oj_output_checker_if
  import oj_check_pkg::*;
#(
  parameter int WIDTH = 1,
  parameter int CNT_W = DEF_CNT_W
);
  // sample_valid has no back-pressure: while the checker is in RUN every cycle
  // with sample_valid=1 is consumed; outside RUN such samples are dropped.
  logic             start;
  logic             sample_valid;
  logic             last;
  logic [WIDTH-1:0] dut_out;
  logic [WIDTH-1:0] ref_out;
  logic [WIDTH-1:0] ref_mask;

  logic             busy;
  logic             done;
  logic             pass;
  logic             overflow;
  logic [CNT_W-1:0] sample_count;
  logic [CNT_W-1:0] mismatch_count;
  logic             first_err_valid;
  logic [CNT_W-1:0] first_err_idx;
  logic [WIDTH-1:0] first_err_dut;
  logic [WIDTH-1:0] first_err_ref;
  state_t           dbg_state;

  modport master (
    output start, sample_valid, last, dut_out, ref_out, ref_mask,
    input  busy, done, pass, overflow, sample_count, mismatch_count,
           first_err_valid, first_err_idx, first_err_dut, first_err_ref, dbg_state
  );

  modport slave (
    input  start, sample_valid, last, dut_out, ref_out, ref_mask,
    output busy, done, pass, overflow, sample_count, mismatch_count,
           first_err_valid, first_err_idx, first_err_dut, first_err_ref, dbg_state
  );
endinterface

// File: rtl/oj_masked_compare.sv
// Combinational masked comparison; an X or Z on any compared bit counts as a
// mismatch because the per-bit test is case-inequality.
module oj_masked_compare #(
  parameter int WIDTH = 1
) (
  input  logic [WIDTH-1:0] i_dut,
  input  logic [WIDTH-1:0] i_ref,
  input  logic [WIDTH-1:0] i_mask,
  output logic             o_mismatch
);

  always_comb begin
    o_mismatch = 1'b0;
    for (int i = 0; i < WIDTH; i++) begin
      if (i_mask[i] && (i_dut[i] !== i_ref[i])) o_mismatch = 1'b1;
    end
  end

endmodule

// File: rtl/oj_output_checker.sv
// Scoreboard stage behind the judged module: counts samples and masked
// mismatches, captures the first failure and latches a pass/fail verdict.
module oj_output_checker
  import oj_check_pkg::*;
#(
  parameter int WIDTH       = 1,
  parameter int CNT_W       = DEF_CNT_W,
  parameter int MAX_SAMPLES = 1024
) (
  input  logic clk,
  input  logic reset,
  oj_output_checker_if.slave bus
);

  if ((longint'(MAX_SAMPLES) >= (longint'(1) << CNT_W)) || (MAX_SAMPLES < 1)) begin : g_bad_cfg
    $error("oj_output_checker: MAX_SAMPLES must be in 1 .. 2**CNT_W-1");
  end

  localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_SAMPLES);

  state_t           r_state;
  logic             r_busy;
  logic             r_done;
  logic             r_pass;
  logic             r_overflow;
  logic [CNT_W-1:0] r_sample_count;
  logic [CNT_W-1:0] r_mismatch_count;
  logic             r_first_err_valid;
  logic [CNT_W-1:0] r_first_err_idx;
  logic [WIDTH-1:0] r_first_err_dut;
  logic [WIDTH-1:0] r_first_err_ref;

  logic             w_mismatch;
  logic             w_accept;
  logic             w_hit_max;
  logic             w_terminate;
  logic             w_overflow_next;
  logic [CNT_W-1:0] w_count_next;
  logic [CNT_W-1:0] w_mm_next;

  oj_masked_compare #(.WIDTH(WIDTH)) u_cmp (
    .i_dut      (bus.dut_out),
    .i_ref      (bus.ref_out),
    .i_mask     (bus.ref_mask),
    .o_mismatch (w_mismatch)
  );

  // Next-value views of the counters let the verdict be latched on the same
  // edge that accepts the terminating sample.
  assign w_accept        = (r_state == ST_RUN) && bus.sample_valid;
  assign w_count_next    = r_sample_count + CNT_W'(1);
  assign w_hit_max       = (w_count_next == MAX_CNT);
  assign w_terminate     = w_accept && (bus.last || w_hit_max);
  assign w_overflow_next = w_hit_max && !bus.last;
  assign w_mm_next       = w_mismatch ? CNT_W'(sat_inc(32'(r_mismatch_count), CNT_W))
                                      : r_mismatch_count;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state           <= ST_IDLE;
      r_busy            <= 1'b0;
      r_done            <= 1'b0;
      r_pass            <= 1'b0;
      r_overflow        <= 1'b0;
      r_sample_count    <= '0;
      r_mismatch_count  <= '0;
      r_first_err_valid <= 1'b0;
      r_first_err_idx   <= '0;
      r_first_err_dut   <= '0;
      r_first_err_ref   <= '0;
    end else begin
      case (r_state)
        ST_IDLE, ST_DONE: begin
          if (bus.start) begin
            r_state           <= ST_RUN;
            r_busy            <= 1'b1;
            r_done            <= 1'b0;
            r_pass            <= 1'b0;
            r_overflow        <= 1'b0;
            r_sample_count    <= '0;
            r_mismatch_count  <= '0;
            r_first_err_valid <= 1'b0;
            r_first_err_idx   <= '0;
            r_first_err_dut   <= '0;
            r_first_err_ref   <= '0;
          end
        end
        ST_RUN: begin
          if (w_accept) begin
            r_sample_count   <= w_count_next;
            r_mismatch_count <= w_mm_next;
            if (w_mismatch && !r_first_err_valid) begin
              r_first_err_valid <= 1'b1;
              r_first_err_idx   <= r_sample_count;
              r_first_err_dut   <= bus.dut_out;
              r_first_err_ref   <= bus.ref_out;
            end
            if (w_terminate) begin
              r_state    <= ST_DONE;
              r_busy     <= 1'b0;
              r_done     <= 1'b1;
              r_overflow <= w_overflow_next;
              r_pass     <= (w_mm_next == '0) && !w_overflow_next;
            end
          end
        end
        default: begin
          r_state <= ST_IDLE;
          r_busy  <= 1'b0;
          r_done  <= 1'b0;
          r_pass  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.busy            = r_busy;
  assign bus.done            = r_done;
  assign bus.pass            = r_pass;
  assign bus.overflow        = r_overflow;
  assign bus.sample_count    = r_sample_count;
  assign bus.mismatch_count  = r_mismatch_count;
  assign bus.first_err_valid = r_first_err_valid;
  assign bus.first_err_idx   = r_first_err_idx;
  assign bus.first_err_dut   = r_first_err_dut;
  assign bus.first_err_ref   = r_first_err_ref;
  assign bus.dbg_state       = r_state;

endmodule

// File: tb/tb_oj_output_checker.sv
// Bench for oj_output_checker: directed scenarios plus random traffic, each
// cycle checked against a run-level model built from the list of accepted samples.
module tb_oj_output_checker;
  import oj_check_pkg::*;

  localparam int W    = 8;
  localparam int CW   = 16;
  localparam int MAXS = 8;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  oj_output_checker_if #(.WIDTH(W), .CNT_W(CW)) bus ();

  oj_output_checker #(.WIDTH(W), .CNT_W(CW), .MAX_SAMPLES(MAXS)) u_dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int n_cmp = 0;
  int n_err = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Model: 0 = idle, 1 = running, 2 = finished. A run is the list of samples
  // accepted so far; every reported figure is derived from that list.
  int              m_phase;
  bit              m_ovf;
  bit              m_pass;
  logic [W-1:0]    exp_q[$];
  logic [W-1:0]    got_q[$];
  logic [W-1:0]    mask_q[$];

  function automatic bit is_bad(input int i);
    return ((got_q[i] ^ exp_q[i]) & mask_q[i]) !== {W{1'b0}};
  endfunction

  function automatic int n_bad();
    int n = 0;
    foreach (got_q[i]) if (is_bad(i)) n++;
    return n;
  endfunction

  function automatic int first_bad();
    foreach (got_q[i]) if (is_bad(i)) return i;
    return -1;
  endfunction

  task automatic clear_run();
    exp_q.delete(); got_q.delete(); mask_q.delete();
    m_ovf = 1'b0; m_pass = 1'b0;
  endtask

  task automatic model_step(input bit rst, input bit st, input bit v, input bit l,
                            input logic [W-1:0] d, input logic [W-1:0] r, input logic [W-1:0] m);
    if (rst) begin
      m_phase = 0;
      clear_run();
    end else if (m_phase != 1 && st) begin
      m_phase = 1;
      clear_run();
    end else if (m_phase == 1 && v) begin
      got_q.push_back(d); exp_q.push_back(r); mask_q.push_back(m);
      if (l) begin
        m_phase = 2; m_ovf = 1'b0; m_pass = (n_bad() == 0);
      end else if (got_q.size() == MAXS) begin
        m_phase = 2; m_ovf = 1'b1; m_pass = 1'b0;
      end
    end
  endtask

  task automatic check_all();
    int fe;
    fe = first_bad();
    check("busy",      32'(bus.busy),     32'(m_phase == 1));
    check("done",      32'(bus.done),     32'(m_phase == 2));
    check("pass",      32'(bus.pass),     32'((m_phase == 2) && m_pass));
    check("overflow",  32'(bus.overflow), 32'(m_ovf));
    check("count",     32'(bus.sample_count),   32'(got_q.size()));
    check("mismatch",  32'(bus.mismatch_count), 32'(n_bad()));
    check("fe_valid",  32'(bus.first_err_valid), 32'(fe >= 0));
    check("fe_idx",    32'(bus.first_err_idx), (fe >= 0) ? 32'(fe) : 32'd0);
    check("fe_dut",    32'(bus.first_err_dut), (fe >= 0) ? 32'(got_q[fe]) : 32'd0);
    check("fe_ref",    32'(bus.first_err_ref), (fe >= 0) ? 32'(exp_q[fe]) : 32'd0);
  endtask

  task automatic drive(input bit rst, input bit st, input bit v, input bit l,
                       input logic [W-1:0] d, input logic [W-1:0] r, input logic [W-1:0] m);
    @(negedge clk);
    reset = rst; bus.start = st; bus.sample_valid = v; bus.last = l;
    bus.dut_out = d; bus.ref_out = r; bus.ref_mask = m;
    @(posedge clk);
    model_step(rst, st, v, l, d, r, m);
    #1;
    check_all();
  endtask

  task automatic idle();      drive(1'b0, 1'b0, 1'b0, 1'b0, '0, '0, '0); endtask
  task automatic go();        drive(1'b0, 1'b1, 1'b0, 1'b0, '0, '0, '0); endtask
  task automatic smp(input logic [W-1:0] d, input logic [W-1:0] r,
                     input logic [W-1:0] m, input bit l);
    drive(1'b0, 1'b0, 1'b1, l, d, r, m);
  endtask

  logic [W-1:0] rd, rr, rm;
  bit           b_rst, b_st, b_v, b_l;

  initial begin
    reset = 1'b1; bus.start = 1'b0; bus.sample_valid = 1'b0; bus.last = 1'b0;
    bus.dut_out = '0; bus.ref_out = '0; bus.ref_mask = '0;
    m_phase = 0; clear_run();
    drive(1'b1, 1'b0, 1'b0, 1'b0, '0, '0, '0);
    drive(1'b1, 1'b1, 1'b1, 1'b1, 8'h12, 8'h34, 8'hFF);
    check("reset.state", 32'(bus.dbg_state), 32'(ST_IDLE));
    smp(8'h01, 8'h00, 8'hFF, 1'b1);              // dropped in IDLE

    // Single-bit match run
    go();
    smp(8'h01, 8'h01, 8'h01, 1'b0); smp(8'h00, 8'h00, 8'h01, 1'b0);
    smp(8'h01, 8'h01, 8'h01, 1'b0); smp(8'h00, 8'h00, 8'h01, 1'b1);
    check("match.pass", 32'(bus.pass), 32'd1);
    check("match.count", 32'(bus.sample_count), 32'd4);
    smp(8'h01, 8'h00, 8'hFF, 1'b0);              // dropped in DONE

    // First-error capture
    go();
    smp(8'h11, 8'h11, 8'hFF, 1'b0); smp(8'h22, 8'h22, 8'hFF, 1'b0);
    smp(8'h3C, 8'h3D, 8'hFF, 1'b0); smp(8'h44, 8'h44, 8'hFF, 1'b0);
    smp(8'h00, 8'h01, 8'hFF, 1'b1);
    check("capture.mm", 32'(bus.mismatch_count), 32'd2);
    check("capture.idx", 32'(bus.first_err_idx), 32'd2);
    check("capture.dut", 32'(bus.first_err_dut), 32'h3C);
    check("capture.ref", 32'(bus.first_err_ref), 32'h3D);
    check("capture.pass", 32'(bus.pass), 32'd0);

    // Masked bits and unknowns
    go(); smp(8'b0000_1x10, 8'b0000_1010, 8'b0000_1011, 1'b1);
    go(); smp(8'b0000_1x10, 8'b0000_1010, 8'b0000_1111, 1'b1);
    go(); smp(8'hA5, 8'h5A, 8'h00, 1'b1);
    check("mask0.pass", 32'(bus.pass), 32'd1);

    // Sample budget: without last, then with last on the final sample
    go(); for (int i = 0; i < MAXS; i++) smp(8'(i), 8'(i), 8'hFF, 1'b0);
    check("ovf.flag", 32'(bus.overflow), 32'd1);
    check("ovf.count", 32'(bus.sample_count), 32'(MAXS));
    go(); for (int i = 0; i < MAXS; i++) smp(8'(i), 8'(i), 8'hFF, i == MAXS - 1);
    check("ovf_last.flag", 32'(bus.overflow), 32'd0);
    check("ovf_last.pass", 32'(bus.pass), 32'd1);

    // Reset mid-run, then a clean short run
    go();
    smp(8'h10, 8'h10, 8'hFF, 1'b0); smp(8'h20, 8'h21, 8'hFF, 1'b0); smp(8'h30, 8'h30, 8'hFF, 1'b0);
    drive(1'b1, 1'b0, 1'b1, 1'b0, 8'h40, 8'h40, 8'hFF);
    check("midreset.count", 32'(bus.sample_count), 32'd0);
    idle(); go();
    smp(8'h55, 8'h55, 8'hFF, 1'b0); smp(8'h66, 8'h66, 8'hFF, 1'b1);
    check("after_reset.pass", 32'(bus.pass), 32'd1);

    // start ignored in RUN; start wins over a sample in DONE; one-sample failing run
    go();
    smp(8'h01, 8'h01, 8'hFF, 1'b0); smp(8'h02, 8'h02, 8'hFF, 1'b0);
    go();
    check("start_in_run.count", 32'(bus.sample_count), 32'd2);
    drive(1'b0, 1'b1, 1'b1, 1'b0, 8'h03, 8'h03, 8'hFF);
    smp(8'h04, 8'h04, 8'hFF, 1'b1);
    drive(1'b0, 1'b1, 1'b1, 1'b1, 8'h05, 8'h05, 8'hFF);
    check("start_in_done.count", 32'(bus.sample_count), 32'd0);
    smp(8'h0F, 8'hF0, 8'hFF, 1'b1);
    check("single_bad.mm", 32'(bus.mismatch_count), 32'd1);
    check("single_bad.pass", 32'(bus.pass), 32'd0);

    // Random traffic
    for (int k = 0; k < 600; k++) begin
      b_rst = ($urandom_range(0, 59) == 0);
      b_st  = ($urandom_range(0, 6) == 0);
      b_v   = ($urandom_range(0, 3) != 0);
      b_l   = ($urandom_range(0, 5) == 0);
      rr    = W'($urandom);
      case ($urandom_range(0, 3))
        0:       rm = '0;
        1:       rm = W'($urandom);
        default: rm = '1;
      endcase
      rd = ($urandom_range(0, 4) == 0) ? (rr ^ W'($urandom_range(1, 255))) : rr;
      drive(b_rst, b_st, b_v, b_l, rd, rr, rm);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
